// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
//   Bundles the signals of the fetch controller that are not clock or reset.
//   Instruction-memory side:
//     imem_req / imem_addr     fetch request and its address (controller drives)
//     imem_ack / imem_rdata    single-cycle completion strobe and its data
//   Execute side:
//     redirect_valid / redirect_target   taken branch or jump and its target
//   Decode side:
//     if_valid / if_pc / if_instr        presented instruction (controller drives)
//     id_ready                           decode accepts the presented instruction
//   Next-PC mux:
//     pc_sel                             0 = pc+4, 1 = redirect or pending target
//   Modport master belongs to the fetch controller. Modport slave is the
//   environment around it: memory, execute and decode.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        pc_sel;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, pc_sel,
    input  imem_ack, imem_rdata, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, pc_sel,
    output imem_ack, imem_rdata, redirect_valid, redirect_target, id_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Instruction-fetch controller. It owns the program counter, issues one fetch
//   at a time to instruction memory, and presents each fetched instruction to
//   decode until decode accepts it. A redirect from execute discards whatever
//   is in flight or being presented, and fetch resumes at the word-aligned
//   target.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    pc_fetch_ctrl_if.master: memory request/ack, redirect, decode
//            handshake and the pc_sel mux select
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | one cycle after reset with no request; a redirect here loads pc
//   FETCH | request at pc outstanding; the ack captures or discards the data
//   HOLD  | instruction presented to decode, waiting for id_ready or redirect
//   DROP  | request at the old pc still open while a redirect is pending; the
//         | ack data is discarded and pc then loads the pending target
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pend_tgt;
  logic [31:0] pend_tgt_nxt;
  logic        if_valid_q;
  logic        if_valid_nxt;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_instr_q;
  logic [31:0] if_instr_nxt;
  logic        load_tgt;

  logic [31:0] tgt_aligned;
  logic [31:0] pc_inc;

  // Targets are forced onto a word boundary before they reach pc or pend_tgt.
  assign tgt_aligned = {bus.redirect_target[31:2], 2'b00};
  // The 32-bit add wraps naturally, so 0xFFFF_FFFC is followed by 0.
  assign pc_inc      = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_tgt   <= 32'h0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_tgt   <= pend_tgt_nxt;
      if_valid_q <= if_valid_nxt;
      if_pc_q    <= if_pc_nxt;
      if_instr_q <= if_instr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_tgt_nxt = pend_tgt;
    if_valid_nxt = if_valid_q;
    if_pc_nxt    = if_pc_q;
    if_instr_nxt = if_instr_q;
    load_tgt     = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (bus.redirect_valid) begin
          pc_nxt   = tgt_aligned;
          load_tgt = 1'b1;
        end
      end

      FETCH: begin
        if (bus.imem_ack) begin
          if (bus.redirect_valid) begin
            // The returning data belongs to the wrong path. Refetch at the
            // target on the next cycle without leaving FETCH.
            pc_nxt   = tgt_aligned;
            load_tgt = 1'b1;
          end else begin
            if_instr_nxt = bus.imem_rdata;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b1;
            state_nxt    = HOLD;
          end
        end else if (bus.redirect_valid) begin
          // The request must stay at the old address until it is acked,
          // so the target is parked until then.
          pend_tgt_nxt = tgt_aligned;
          state_nxt    = DROP;
        end
      end

      DROP: begin
        if (bus.imem_ack) begin
          // A redirect arriving in the ack cycle is newer than the parked
          // target, so it takes precedence.
          pc_nxt    = bus.redirect_valid ? tgt_aligned : pend_tgt;
          load_tgt  = 1'b1;
          state_nxt = FETCH;
        end else if (bus.redirect_valid) begin
          pend_tgt_nxt = tgt_aligned;
        end
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          if_valid_nxt = 1'b0;
          pc_nxt       = tgt_aligned;
          load_tgt     = 1'b1;
          state_nxt    = FETCH;
        end else if (bus.id_ready) begin
          if_valid_nxt = 1'b0;
          pc_nxt       = pc_inc;
          state_nxt    = FETCH;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.imem_req  = (state == FETCH) || (state == DROP);
  assign bus.imem_addr = pc;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  // Gated with rst_n so that a redirect seen while reset is held cannot
  // raise the mux select.
  assign bus.pc_sel    = load_tgt & rst_n;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst_n;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        sel;
  } fexp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } xexp_t;

  fexp_t fq[$];
  xexp_t xq[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    ack_budget = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder. It acks while a request is open and the test has
  // granted acks. The returned data is the bitwise inverse of the address.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (bus.imem_ack && ack_budget > 0) ack_budget--;
      #2;
      if (rst_n && bus.imem_req && ack_budget > 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = ~bus.imem_addr;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
      end
    end
  end

  // Monitor: compares acked fetches and decode transfers against the queues.
  fexp_t fe;
  xexp_t xe;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (fq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", bus.imem_addr);
        end else begin
          fe = fq.pop_front();
          check("fetch_addr", bus.imem_addr, fe.addr);
          check("fetch_pc_sel", {31'h0, bus.pc_sel}, {31'h0, fe.sel});
        end
      end
      if (bus.if_valid && bus.id_ready && !bus.redirect_valid) begin
        if (xq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL xfer_unexpected: got pc %h expected no transfer", bus.if_pc);
        end else begin
          xe = xq.pop_front();
          check("xfer_pc", bus.if_pc, xe.pc);
          check("xfer_instr", bus.if_instr, xe.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_f(input logic [31:0] a, input logic s);
    fexp_t e;
    e.addr = a;
    e.sel  = s;
    fq.push_back(e);
  endtask

  task automatic push_x(input logic [31:0] p, input logic [31:0] i);
    xexp_t e;
    e.pc    = p;
    e.instr = i;
    xq.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((fq.size() != 0 || xq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check(name, {31'h0, (fq.size() == 0 && xq.size() == 0)}, 32'h1);
    fq.delete();
    xq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.id_ready        = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", {31'h0, bus.if_valid}, 32'h0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_pc_sel", {31'h0, bus.pc_sel}, 32'h0);

    // Sequential stream 0, 4, 8 with zero-wait ack and decode always ready
    step();
    rst_n        = 1'b1;
    bus.id_ready = 1'b1;
    push_f(32'h0, 1'b0); push_x(32'h0, 32'hFFFF_FFFF);
    push_f(32'h4, 1'b0); push_x(32'h4, 32'hFFFF_FFFB);
    push_f(32'h8, 1'b0); push_x(32'h8, 32'hFFFF_FFF7);
    ack_budget = 3;
    drain("seq_drain");

    // Decode stalls for 5 cycles: the presented instruction must hold
    bus.id_ready = 1'b0;
    push_f(32'hC, 1'b0);
    ack_budget = 1;
    n = 0;
    while (!bus.if_valid && n < 20) begin
      step();
      n++;
    end
    check("hold_reached", {31'h0, bus.if_valid}, 32'h1);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {31'h0, bus.if_valid}, 32'h1);
      check("hold_pc", bus.if_pc, 32'hC);
      check("hold_instr", bus.if_instr, 32'hFFFF_FFF3);
      check("hold_no_req", {31'h0, bus.imem_req}, 32'h0);
    end
    step();
    push_x(32'hC, 32'hFFFF_FFF3);
    bus.id_ready = 1'b1;
    drain("hold_drain");

    // Redirect to 0x100 in FETCH while the ack is held off
    bus.id_ready        = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    @(negedge clk);
    check("redir_nack_pc_sel", {31'h0, bus.pc_sel}, 32'h0);
    check("redir_addr0", bus.imem_addr, 32'h10);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("drop_req", {31'h0, bus.imem_req}, 32'h1);
    check("drop_addr1", bus.imem_addr, 32'h10);
    step();
    @(negedge clk);
    check("drop_addr2", bus.imem_addr, 32'h10);
    step();
    push_f(32'h10, 1'b1);
    push_f(32'h100, 1'b0);
    ack_budget = 2;
    drain("drop_drain");
    check("tgt_hold_valid", {31'h0, bus.if_valid}, 32'h1);
    check("tgt_hold_pc", bus.if_pc, 32'h100);

    // Redirect and id_ready together in HOLD: redirect wins, target 0x203 aligns to 0x200
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h203;
    bus.id_ready        = 1'b1;
    @(negedge clk);
    check("hold_redir_pc_sel", {31'h0, bus.pc_sel}, 32'h1);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("hold_redir_valid", {31'h0, bus.if_valid}, 32'h0);
    check("hold_redir_addr", bus.imem_addr, 32'h200);
    check("hold_redir_req", {31'h0, bus.imem_req}, 32'h1);
    step();
    push_f(32'h200, 1'b0);
    push_x(32'h200, 32'hFFFF_FDFF);
    ack_budget = 1;
    drain("align_drain");

    // Redirect coinciding with the ack in FETCH, then wrap from 0xFFFF_FFFC to 0
    push_f(32'h204, 1'b1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    ack_budget = 1;
    step();
    bus.redirect_valid = 1'b0;
    push_f(32'hFFFF_FFFC, 1'b0); push_x(32'hFFFF_FFFC, 32'h0000_0003);
    push_f(32'h0, 1'b0);         push_x(32'h0, 32'hFFFF_FFFF);
    ack_budget = 2;
    drain("wrap_drain");

    // Two redirects during the open request: the later target wins
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h300;
    step();
    bus.redirect_target = 32'h400;
    step();
    bus.redirect_valid = 1'b0;
    push_f(32'h4, 1'b1);
    push_f(32'h400, 1'b0); push_x(32'h400, 32'hFFFF_FBFF);
    ack_budget = 2;
    drain("latest_drain");

    // Reset pulse while in DROP
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h500;
    step();
    bus.redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_drop_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_drop_addr", bus.imem_addr, 32'h0);
    check("rst_drop_valid", {31'h0, bus.if_valid}, 32'h0);
    check("rst_drop_pc_sel", {31'h0, bus.pc_sel}, 32'h0);
    check("rst_drop_if_pc", bus.if_pc, 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_req", {31'h0, bus.imem_req}, 32'h0);
    step();
    @(negedge clk);
    check("post_rst_req", {31'h0, bus.imem_req}, 32'h1);
    check("post_rst_addr", bus.imem_addr, 32'h0);
    step();
    push_f(32'h0, 1'b0); push_x(32'h0, 32'hFFFF_FFFF);
    ack_budget = 1;
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
